// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, coefficients and FSM encoding for the serial FIR
package fir_pkg;

    localparam int DW    = 12;
    localparam int CW    = 12;
    localparam int NTAP  = 16;
    localparam int OW    = 29;
    localparam int NHALF = NTAP / 2;
    localparam int PW    = DW + 1;
    localparam int MW    = PW + CW;
    localparam int CNTW  = $clog2(NHALF);
    localparam int XIW   = $clog2(NTAP);

    // Lower half of the symmetric kernel; tap 15-k reuses entry k.
    localparam logic [CW-1:0] FIR_COE [0:NHALF-1] = '{
        12'd11, 12'd31, 12'd63, 12'd104, 12'd152, 12'd198, 12'd235, 12'd255
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MAC  = 1'b1
    } fir_state_t;

endpackage

// File: rtl/fir_mac_unit.sv
// rtl/fir_mac_unit.sv - symmetric pre-adder, multiplier and accumulator
module fir_mac_unit
    import fir_pkg::*;
(
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [DW-1:0] i_xa,
    input  logic [DW-1:0] i_xb,
    input  logic [CW-1:0] i_coe,
    output logic [OW-1:0] o_sum
);

    logic [PW-1:0] w_pre;
    logic [MW-1:0] w_prod;
    logic [OW-1:0] r_acc;

    assign w_pre  = {1'b0, i_xa} + {1'b0, i_xb};
    assign w_prod = MW'(w_pre) * MW'(i_coe);
    // o_sum includes the current product so the last pair needs no extra cycle.
    assign o_sum  = r_acc + OW'(w_prod);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= o_sum;
        end
    end

endmodule

// File: rtl/fir_serial.sv
// rtl/fir_serial.sv - 16-tap symmetric FIR, one MAC time-shared over 8 cycles per sample
module fir_serial
    import fir_pkg::*;
(
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic [DW-1:0] xin,
    output logic          ready,
    output logic          valid,
    output logic [OW-1:0] yout,
    output logic          ovf,
    input  logic          ovf_clr
);

    fir_state_t     r_state;
    fir_state_t     w_state_nxt;
    logic [DW-1:0]  r_x [0:NTAP-1];
    logic [CNTW-1:0] r_cnt;
    logic [OW-1:0]  r_yout;
    logic           r_valid;
    logic           r_ovf;

    logic           w_ready;
    logic           w_mac_en;
    logic           w_last;
    logic           w_accept;
    logic           w_overrun;
    logic [XIW-1:0] w_idx_a;
    logic [XIW-1:0] w_idx_b;
    logic [CW-1:0]  w_coe;
    logic [OW-1:0]  w_sum;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (en) w_state_nxt = ST_MAC;
            ST_MAC:  if (r_cnt == CNTW'(NHALF - 1)) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ready  = 1'b0;
        w_mac_en = 1'b0;
        w_last   = 1'b0;
        case (r_state)
            ST_IDLE: w_ready = 1'b1;
            ST_MAC: begin
                w_mac_en = 1'b1;
                w_last   = (r_cnt == CNTW'(NHALF - 1));
            end
            default: w_ready = 1'b0;
        endcase
    end

    assign w_accept  = en & w_ready;
    assign w_overrun = en & ~w_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NTAP; k++) r_x[k] <= '0;
        end else if (w_accept) begin
            r_x[0] <= xin;
            for (int k = 1; k < NTAP; k++) r_x[k] <= r_x[k-1];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (w_mac_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Pair k folds tap k with its mirror tap NTAP-1-k.
    assign w_idx_a = XIW'(r_cnt);
    assign w_idx_b = XIW'(NTAP - 1) - w_idx_a;
    assign w_coe   = FIR_COE[r_cnt];

    fir_mac_unit u_mac (
        .clk   (clk),
        .rstn  (rstn),
        .i_clr (w_accept),
        .i_en  (w_mac_en),
        .i_xa  (r_x[w_idx_a]),
        .i_xb  (r_x[w_idx_b]),
        .i_coe (w_coe),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_yout  <= '0;
        end else begin
            r_valid <= w_last;
            if (w_last) r_yout <= w_sum;
        end
    end

    // A dropped sample in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
        end else if (w_overrun) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign ready = w_ready;
    assign valid = r_valid;
    assign yout  = r_yout;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_fir_serial.sv
// tb/tb_fir_serial.sv - randomized self-checking bench for fir_serial against a direct-form model
module tb_fir_serial;
    import fir_pkg::*;

    logic          clk = 1'b0;
    logic          rstn;
    logic          en;
    logic [DW-1:0] xin;
    logic          ovf_clr;
    logic          ready;
    logic          valid;
    logic [OW-1:0] yout;
    logic          ovf;

    fir_serial dut (
        .clk     (clk),
        .rstn    (rstn),
        .en      (en),
        .xin     (xin),
        .ready   (ready),
        .valid   (valid),
        .yout    (yout),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    int coef16 [16] = '{11, 31, 63, 104, 152, 198, 235, 255,
                        255, 235, 198, 152, 104, 63, 31, 11};
    int hist [16];
    int busy;
    int vcnt;
    int pend_y;
    int m_yout;
    bit m_ovf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_out();
        int s = 0;
        for (int k = 0; k < 16; k++) s += coef16[k] * hist[k];
        return s;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 16; k++) hist[k] = 0;
        busy = 0; vcnt = 0; pend_y = 0; m_yout = 0; m_ovf = 0;
    endtask

    // One clock: check the current cycle's outputs, drive inputs, advance model and DUT.
    task automatic step(input bit e, input int x, input bit clr);
        if (vcnt == 1) m_yout = pend_y;
        chk("ready", 32'(ready), 32'(busy == 0));
        chk("valid", 32'(valid), 32'(vcnt == 1));
        chk("yout",  32'(yout),  32'(m_yout));
        chk("ovf",   32'(ovf),   32'(m_ovf));
        en      = e;
        xin     = x[DW-1:0];
        ovf_clr = clr;
        if (e && busy != 0) m_ovf = 1'b1;
        else if (clr)       m_ovf = 1'b0;
        if (e && busy == 0) begin
            for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = x;
            pend_y  = ref_out();
            busy    = 8;
            vcnt    = 9;
        end else begin
            if (busy > 0) busy--;
            if (vcnt > 0) vcnt--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int x);
        step(1'b1, x, 1'b0);
        repeat (8) step(1'b0, 0, 1'b0);
    endtask

    task automatic do_reset(input int hold);
        en = 1'b0; ovf_clr = 1'b0; xin = '0;
        rstn = 1'b0;
        #2;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_yout",  32'(yout),  32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_ovf",   32'(ovf),   32'd0);
        repeat (hold) @(posedge clk);
        #1;
        rstn = 1'b1;
        model_clear();
    endtask

    task automatic impulse_run(input string tag);
        sample(1);
        chk(tag, 32'(yout), 32'(coef16[0]));
        for (int i = 1; i <= 16; i++) begin
            sample(0);
            chk(tag, 32'(yout), (i < 16) ? 32'(coef16[i]) : 32'd0);
        end
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; xin = '0; ovf_clr = 1'b0;
        model_clear();
        #1;
        do_reset(2);

        impulse_run("impulse");

        for (int i = 0; i < 20; i++) begin
            sample(100);
            if (i >= 15) chk("step_settle", 32'(yout), 32'd209800);
        end

        for (int i = 0; i < 16; i++) sample(4095);
        chk("full_scale", 32'(yout), 32'd8591310);

        step(1'b1, 5, 1'b0);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        step(1'b1, 7, 1'b0);
        repeat (5) step(1'b0, 0, 1'b0);
        chk("ovr_flag", 32'(ovf), 32'd1);
        chk("ovr_y", 32'(yout), 32'd8546320);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0);
        chk("ovr_clr", 32'(ovf), 32'd0);

        step(1'b1, 3, 1'b0);
        step(1'b1, 9, 1'b1);
        step(1'b0, 0, 1'b0);
        chk("ovr_set_wins", 32'(ovf), 32'd1);
        repeat (7) step(1'b0, 0, 1'b1);

        for (int i = 0; i < 45; i++) step(1'b1, int'($urandom_range(0, 4095)), 1'b0);
        repeat (9) step(1'b0, 0, 1'b0);

        step(1'b1, 1234, 1'b0);
        repeat (3) step(1'b0, 0, 1'b0);
        do_reset(1);
        repeat (12) step(1'b0, 0, 1'b0);
        impulse_run("impulse_after_rst");

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) == 0, int'($urandom_range(0, 4095)),
                 $urandom_range(0, 15) == 0);
        repeat (10) step(1'b0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
